// File: rtl/bcd_pkg.sv
// Shared BCD types, digit limits and validity helper for the multi-decade counter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    function automatic logic bcd_valid(input bcd_digit_t digit);
        return (digit <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade cell: holds a single BCD digit, loads (with sanitising) or steps up/down.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       step_in,
    input  logic       up,
    input  logic       load,
    input  bcd_digit_t load_digit,
    output bcd_digit_t digit,
    output logic       at_max,
    output logic       at_min
);

    bcd_digit_t digit_q;
    bcd_digit_t digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = bcd_valid(load_digit) ? load_digit : BCD_MIN;
        end else if (step_in) begin
            // Out-of-range values can only appear before the first reset; fold them onto a legal digit.
            if (up) begin
                digit_d = (digit_q >= BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
            end else begin
                digit_d = (digit_q == BCD_MIN || !bcd_valid(digit_q)) ? BCD_MAX : digit_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digit_q <= BCD_MIN;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit  = digit_q;
    assign at_max = (digit_q == BCD_MAX);
    assign at_min = (digit_q == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// Parametrised multi-decade BCD up/down counter with validated parallel load
// and a combinational, cascadable terminal-count output.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  load_error
);

    // step[i] is the step request into digit i; step[DIGITS] is the carry/borrow out.
    logic [DIGITS:0]   step;
    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_min;
    logic [DIGITS-1:0] digit_bad;
    logic              load_error_q;
    logic              load_error_d;

    assign step[0] = enable;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk        (clk),
            .reset      (reset),
            .step_in    (step[i]),
            .up         (up),
            .load       (load),
            .load_digit (load_value[4*i +: 4]),
            .digit      (count[4*i +: 4]),
            .at_max     (at_max[i]),
            .at_min     (at_min[i])
        );

        assign step[i+1]    = step[i] & (up ? at_max[i] : at_min[i]);
        assign digit_bad[i] = ~bcd_valid(load_value[4*i +: 4]);
    end

    assign tc = step[DIGITS];

    assign load_error_d = load & (|digit_bad);

    always_ff @(posedge clk) begin
        if (reset) begin
            load_error_q <= 1'b0;
        end else begin
            load_error_q <= load_error_d;
        end
    end

    assign load_error = load_error_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench: vector table + scoreboard on a 4-decade counter, plus a
// two-instance cascade checked against an integer reference model.
module tb_bcd_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable, up, load;
    logic [15:0] load_value, count;
    logic        tc, load_error;

    bcd_updown_counter #(.DIGITS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .up         (up),
        .load       (load),
        .load_value (load_value),
        .count      (count),
        .tc         (tc),
        .load_error (load_error)
    );

    logic        c_reset, c_en, c_up, c_load;
    logic [15:0] c_lv;
    logic [7:0]  lo_cnt, hi_cnt;
    logic        lo_tc, hi_tc, lo_err, hi_err;

    bcd_updown_counter #(.DIGITS(2)) u_lo (
        .clk(clk), .reset(c_reset), .enable(c_en), .up(c_up), .load(c_load),
        .load_value(c_lv[7:0]), .count(lo_cnt), .tc(lo_tc), .load_error(lo_err)
    );

    bcd_updown_counter #(.DIGITS(2)) u_hi (
        .clk(clk), .reset(c_reset), .enable(lo_tc), .up(c_up), .load(c_load),
        .load_value(c_lv[15:8]), .count(hi_cnt), .tc(hi_tc), .load_error(hi_err)
    );

    typedef struct {
        logic        r;
        logic        l;
        logic [15:0] lv;
        logic        en;
        logic        u;
        logic [15:0] exp_cnt;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [15:0] cnt;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   m_val    = 0;
    int   cm       = 0;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd(input logic [15:0] b);
        int v;
        v = 0;
        for (int i = 3; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [15:0] sanitize(input logic [15:0] b);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = (b[4*i +: 4] > 4'd9) ? 4'd0 : b[4*i +: 4];
        return r;
    endfunction

    function automatic logic has_bad(input logic [15:0] b);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) if (b[4*i +: 4] > 4'd9) bad = 1'b1;
        return bad;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic apply(input logic r, input logic l, input logic [15:0] lv, input logic en,
                         input logic u, input logic [15:0] exp_cnt, input logic exp_err,
                         input string tag);
        exp_t e;
        reset = r; load = l; load_value = lv; enable = en; up = u;
        #1;
        check({tag, " tc"}, 32'(tc), 32'(en & (u ? (m_val == 9999) : (m_val == 0))));
        e.cnt = exp_cnt;
        e.err = exp_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, " count"}, 32'(count), 32'(e.cnt));
        check({tag, " load_error"}, 32'(load_error), 32'(e.err));
        m_val = from_bcd(e.cnt);
    endtask

    task automatic step_model(input logic r, input logic l, input logic [15:0] lv,
                              input logic en, input logic u, input string tag);
        int   nv;
        logic ne;
        nv = m_val;
        ne = 1'b0;
        if (r) nv = 0;
        else if (l) begin
            nv = from_bcd(sanitize(lv));
            ne = has_bad(lv);
        end else if (en) nv = u ? (m_val + 1) % 10000 : (m_val + 9999) % 10000;
        apply(r, l, lv, en, u, to_bcd(nv), ne, tag);
    endtask

    task automatic casc(input logic r, input logic l, input logic [15:0] lv,
                        input logic en, input logic u);
        c_reset = r; c_load = l; c_lv = lv; c_en = en; c_up = u;
        #1;
        check("cascade tc", 32'(hi_tc), 32'(en & (u ? (cm == 9999) : (cm == 0))));
        if (r) cm = 0;
        else if (l) cm = from_bcd(sanitize(lv));
        else if (en) cm = u ? (cm + 1) % 10000 : (cm + 9999) % 10000;
        @(posedge clk);
        #1;
        check("cascade count", 32'({hi_cnt, lo_cnt}), 32'(to_bcd(cm)));
    endtask

    vec_t vecs[19];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 16'h1299, 1'b1, 1'b1, 16'h1299, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1300, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 16'h3A5F, 1'b0, 1'b1, 16'h3050, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h3050, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 16'h4567, 1'b0, 1'b1, 16'h4567, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h9999, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h9998, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 16'hAAAA, 1'b1, 1'b0, 16'h0000, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 16'h0999, 1'b1, 1'b1, 16'h0999, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1000, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0999, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1000, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1000, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 16'h9999, 1'b0, 1'b1, 16'h9999, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h9999, 1'b0};

        reset = 1'b1; load = 1'b0; load_value = '0; enable = 1'b0; up = 1'b1;
        c_reset = 1'b1; c_load = 1'b0; c_lv = '0; c_en = 1'b0; c_up = 1'b1;
        #2;
        @(posedge clk);
        #1;
        m_val = 0;
        cm = 0;

        for (int i = 0; i < 19; i++) begin
            apply(vecs[i].r, vecs[i].l, vecs[i].lv, vecs[i].en, vecs[i].u,
                  vecs[i].exp_cnt, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        step_model(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, "upcount reset");
        for (int i = 0; i < 10000; i++) step_model(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, "upcount");
        check("upcount wrapped", 32'(count), 32'h0000);
        for (int i = 0; i < 3; i++) step_model(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, "downwrap");

        casc(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        casc(1'b0, 1'b1, 16'h0095, 1'b1, 1'b1);
        check("cascade load_error", 32'(lo_err | hi_err), 32'(0));
        for (int i = 0; i < 10; i++) casc(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) casc(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        casc(1'b0, 1'b1, 16'h9995, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) casc(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) casc(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        begin
            logic u;
            u = 1'b1;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 7) == 0) u = ~u;
                casc(1'b0, 1'b0, 16'h0, ($urandom_range(0, 3) != 0), u);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
